// File: rtl/hal_cfg_lut_pkg.sv
// Shared definitions for the configurable LUT: FSM encoding, legal K range
// and the table-width helper.
package hal_cfg_lut_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_READ   = 2'd3
    } state_t;

    localparam int K_MIN = 2;
    localparam int K_MAX = 6;

    function automatic int tbl_w(input int k);
        return 1 << k;
    endfunction

endpackage

// File: rtl/hal_cfg_shreg.sv
// Table-wide shift register shared by serial load (shadow) and readback.
// Parallel load has priority over shift; shifts left with serial LSB input.
module hal_cfg_shreg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_en,
    input  logic [W-1:0] load_val,
    input  logic         shift_en,
    input  logic         sin,
    output logic [W-1:0] q,
    output logic         msb
);

    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load_en) begin
            data_d = load_val;
        end else if (shift_en) begin
            data_d = {data_q[W-2:0], sin};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q   = data_q;
    assign msb = data_q[W-1];

endmodule

// File: rtl/hal_cfg_lut4.sv
// K-input LUT with serial reconfiguration and serial readback of the active
// table; the table swaps atomically in COMMIT so O never sees a partial load.
//
// state  | meaning
// IDLE   | waiting for CFG_START or RB_REQ
// LOAD   | accepting serial table bits into the shadow register
// COMMIT | one cycle; shadow copied into active table at its end
// READ   | presenting the active table serially, MSB first
module hal_cfg_lut4
    import hal_cfg_lut_pkg::*;
#(
    parameter int                  K    = 4,
    parameter logic [(1<<K)-1:0]   INIT = '0
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [K-1:0] I,
    output logic         O,
    input  logic         CFG_START,
    input  logic         CFG_VALID,
    input  logic         CFG_DATA,
    output logic         CFG_READY,
    input  logic         RB_REQ,
    output logic         RB_VALID,
    output logic         RB_DATA,
    input  logic         RB_READY,
    output logic         BUSY,
    output logic         CFG_ERR
);

    localparam int W = tbl_w(K);

    state_t         state_q, state_d;
    logic [K-1:0]   cnt_q, cnt_d;
    logic [W-1:0]   active_q, active_d;
    logic           err_q, err_d;
    logic           cfg_ready_q, cfg_ready_d;
    logic           rb_valid_q, rb_valid_d;
    logic           busy_q, busy_d;

    logic           sr_load, sr_shift, sr_sin, sr_msb;
    logic [W-1:0]   sr_q;
    logic           cfg_xfer, rb_xfer;

    assign cfg_xfer = cfg_ready_q & CFG_VALID;
    assign rb_xfer  = rb_valid_q & RB_READY;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        err_d    = err_q;
        sr_load  = 1'b0;
        sr_shift = 1'b0;
        sr_sin   = 1'b0;
        // Any new request while an operation is running is a protocol error.
        if (state_q != ST_IDLE && (CFG_START || RB_REQ)) begin
            err_d = 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (CFG_START) begin
                    state_d = ST_LOAD;
                    cnt_d   = '1;
                    err_d   = 1'b0;
                end else if (RB_REQ) begin
                    state_d = ST_READ;
                    cnt_d   = '1;
                    sr_load = 1'b1;
                end
            end
            ST_LOAD: begin
                if (cfg_xfer) begin
                    sr_shift = 1'b1;
                    sr_sin   = CFG_DATA;
                    cnt_d    = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_d = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                active_d = sr_q;
                state_d  = ST_IDLE;
            end
            ST_READ: begin
                if (rb_xfer) begin
                    sr_shift = 1'b1;
                    cnt_d    = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        cfg_ready_d = (state_d == ST_LOAD);
        rb_valid_d  = (state_d == ST_READ);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            active_q    <= INIT;
            err_q       <= 1'b0;
            cfg_ready_q <= 1'b0;
            rb_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            active_q    <= active_d;
            err_q       <= err_d;
            cfg_ready_q <= cfg_ready_d;
            rb_valid_q  <= rb_valid_d;
            busy_q      <= busy_d;
        end
    end

    hal_cfg_shreg #(.W(W)) u_shreg (
        .clk      (CLK),
        .rst      (RST),
        .load_en  (sr_load),
        .load_val (active_q),
        .shift_en (sr_shift),
        .sin      (sr_sin),
        .q        (sr_q),
        .msb      (sr_msb)
    );

    assign O         = active_q[I];
    assign CFG_READY = cfg_ready_q;
    assign RB_VALID  = rb_valid_q;
    assign RB_DATA   = rb_valid_q & sr_msb;
    assign BUSY      = busy_q;
    assign CFG_ERR   = err_q;

endmodule

// File: tb/tb_hal_cfg_lut4.sv
// Directed bench for hal_cfg_lut4 (K=4, INIT=16'h8000); readback bits are
// checked by a queue-based scoreboard monitor.
module tb_hal_cfg_lut4;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] I = 4'd0;
    logic       O;
    logic       CFG_START = 1'b0;
    logic       CFG_VALID = 1'b0;
    logic       CFG_DATA = 1'b0;
    logic       CFG_READY;
    logic       RB_REQ = 1'b0;
    logic       RB_VALID;
    logic       RB_DATA;
    logic       RB_READY = 1'b0;
    logic       BUSY;
    logic       CFG_ERR;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic sb[$];

    always #5 CLK = ~CLK;

    hal_cfg_lut4 #(.K(4), .INIT(16'h8000)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .I         (I),
        .O         (O),
        .CFG_START (CFG_START),
        .CFG_VALID (CFG_VALID),
        .CFG_DATA  (CFG_DATA),
        .CFG_READY (CFG_READY),
        .RB_REQ    (RB_REQ),
        .RB_VALID  (RB_VALID),
        .RB_DATA   (RB_DATA),
        .RB_READY  (RB_READY),
        .BUSY      (BUSY),
        .CFG_ERR   (CFG_ERR)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic monitor();
        logic exp_bit;
        forever begin
            @(negedge CLK);
            if (RB_VALID && RB_READY) begin
                if (sb.size() == 0) begin
                    check("rb_unexpected", 32'(RB_VALID), 32'd0);
                end else begin
                    exp_bit = sb.pop_front();
                    check("rb_data", 32'(RB_DATA), 32'(exp_bit));
                end
            end
        end
    endtask

    task automatic sweep(input logic [15:0] t, input string nm);
        for (int i = 0; i < 16; i++) begin
            I = 4'(i);
            #1;
            check(nm, 32'(O), 32'(t[i]));
        end
    endtask

    task automatic do_load(input logic [15:0] d, input bit gaps, input int err_bit,
                           input int stop_after, input bit with_rb,
                           input logic [3:0] isel, input logic exp_old);
        int   n;
        int   cyc;
        logic v;
        I = isel;
        CFG_START = 1'b1;
        RB_REQ = with_rb;
        tick();
        CFG_START = 1'b0;
        RB_REQ = 1'b0;
        check("load_ready", 32'(CFG_READY), 32'd1);
        check("load_err_clear", 32'(CFG_ERR), 32'd0);
        if (with_rb) begin
            check("both_busy", 32'(BUSY), 32'd1);
            check("both_no_rb", 32'(RB_VALID), 32'd0);
        end
        n = 0;
        cyc = 0;
        while (n < 16 && n != stop_after && cyc < 100) begin
            v = gaps ? (cyc % 4 != 1) : 1'b1;
            CFG_VALID = v;
            CFG_DATA = d[15-n];
            CFG_START = (n == err_bit);
            tick();
            if (v) begin
                n++;
                if (n == 8) check("o_mid_load", 32'(O), 32'(exp_old));
            end
            cyc++;
        end
        CFG_VALID = 1'b0;
        CFG_START = 1'b0;
        if (cyc >= 100) check("load_timeout", 32'(cyc), 32'd0);
        if (n == 16) begin
            check("commit_busy", 32'(BUSY), 32'd1);
            check("commit_not_ready", 32'(CFG_READY), 32'd0);
            check("commit_o_old", 32'(O), 32'(exp_old));
            tick();
            check("post_commit_idle", 32'(BUSY), 32'd0);
            check("post_commit_o_new", 32'(O), 32'(d[isel]));
        end
    endtask

    task automatic do_rb(input logic [15:0] d, input int stall_at);
        int sent;
        int cyc;
        int stall;
        for (int i = 15; i >= 0; i--) sb.push_back(d[i]);
        RB_REQ = 1'b1;
        RB_READY = 1'b1;
        tick();
        RB_REQ = 1'b0;
        check("rb_valid_start", 32'(RB_VALID), 32'd1);
        sent = 0;
        cyc = 0;
        stall = 0;
        while (sent < 16 && cyc < 100) begin
            if (sent == stall_at && stall < 3) begin
                RB_READY = 1'b0;
                #1;
                check("rb_hold_data", 32'(RB_DATA), 32'(d[15-sent]));
                check("rb_hold_valid", 32'(RB_VALID), 32'd1);
                stall++;
            end else begin
                RB_READY = 1'b1;
            end
            if (sent == 15 && RB_READY) check("rb_busy_last", 32'(BUSY), 32'd1);
            if (RB_READY && RB_VALID) sent++;
            tick();
            cyc++;
        end
        RB_READY = 1'b0;
        if (cyc >= 100) check("rb_timeout", 32'(cyc), 32'd0);
        check("rb_done_busy", 32'(BUSY), 32'd0);
        check("rb_done_valid", 32'(RB_VALID), 32'd0);
        check("rb_sb_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            monitor();
        join_none

        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_cfg_ready", 32'(CFG_READY), 32'd0);
        check("rst_rb_valid", 32'(RB_VALID), 32'd0);
        check("rst_rb_data", 32'(RB_DATA), 32'd0);
        check("rst_cfg_err", 32'(CFG_ERR), 32'd0);
        sweep(16'h8000, "rst_sweep");

        // Gapped load of 16'h6996 observed on I=1 (old 0, new 1).
        do_load(16'h6996, 1'b1, -1, 16, 1'b0, 4'd1, 1'b0);
        I = 4'b0011;
        #1;
        check("o_i3_new", 32'(O), 32'd0);

        do_rb(16'h6996, 6);

        // Error injection: CFG_START at bit 5 must not disturb the load.
        do_load(16'hA5C3, 1'b0, 5, 16, 1'b0, 4'd0, 1'b0);
        check("err_set", 32'(CFG_ERR), 32'd1);
        sweep(16'hA5C3, "err_load_sweep");
        do_load(16'h6996, 1'b0, -1, 16, 1'b0, 4'd1, 1'b1);
        check("err_cleared", 32'(CFG_ERR), 32'd0);

        // Reset mid-load: partial data discarded, INIT restored.
        do_load(16'h1234, 1'b0, -1, 8, 1'b0, 4'd0, 1'b0);
        check("midload_busy", 32'(BUSY), 32'd1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("midrst_busy", 32'(BUSY), 32'd0);
        check("midrst_ready", 32'(CFG_READY), 32'd0);
        sweep(16'h8000, "midrst_sweep");
        do_rb(16'h8000, -1);

        // CFG_START and RB_REQ together: load wins, no error.
        do_load(16'h3C0F, 1'b0, -1, 16, 1'b1, 4'd0, 1'b0);
        check("both_err", 32'(CFG_ERR), 32'd0);
        check("both_rb_after", 32'(RB_VALID), 32'd0);
        sweep(16'h3C0F, "both_sweep");

        check("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hal_cfg_lut4.md
HAL_CFG_LUT4 -- requirements
Module: hal_cfg_lut4

Interface
REQ-001 Parameter K, default 4, number of LUT inputs; legal range 2..6.
REQ-002 Parameter INIT, default 16'h0000 (width 2^K), truth table loaded on reset; bit n = O for I == n.
REQ-003 CLK  in  1  sole clock; all state updates on rising edge.
REQ-004 RST  in  1  reset; synchronous, active-high.
REQ-005 I  in  K  LUT select inputs.
REQ-006 O  out  1  LUT output = active_table[I], combinational from I and active table.
REQ-007 CFG_START  in  1  one-cycle request to begin serial table load.
REQ-008 CFG_VALID  in  1  CFG_DATA valid.
REQ-009 CFG_DATA  in  1  serial table bit, MSB (bit 2^K-1) first.
REQ-010 CFG_READY  out  1  block accepts CFG_DATA this cycle.
REQ-011 RB_REQ  in  1  one-cycle request to read back active table.
REQ-012 RB_VALID  out  1  RB_DATA valid.
REQ-013 RB_DATA  out  1  serial readback bit, MSB first.
REQ-014 RB_READY  in  1  consumer accepts RB_DATA this cycle.
REQ-015 BUSY  out  1  high whenever state != IDLE.
REQ-016 CFG_ERR  out  1  sticky protocol-error flag.

Function
REQ-017 FSM states: IDLE, LOAD, COMMIT, READ.
REQ-018 IDLE: CFG_START -> LOAD, bit counter = 2^K-1; else RB_REQ -> READ, shift register <= active table, counter = 2^K-1.
REQ-019 CFG_START and RB_REQ in the same IDLE cycle: CFG_START wins, RB_REQ dropped without error.
REQ-020 LOAD: CFG_READY = 1; bit transfers only when CFG_VALID && CFG_READY, shifted into the shadow register LSB-in; counter decrements per transfer.
REQ-021 CFG_VALID gaps in LOAD are legal; they stall the counter with no timeout.
REQ-022 Transfer with counter == 0 -> COMMIT; COMMIT lasts exactly one cycle, CFG_READY = 0, active table <= shadow at end of COMMIT, -> IDLE.
REQ-023 O reflects the old table through the COMMIT cycle and the new table from the cycle after COMMIT; no partial table is ever visible on O.
REQ-024 READ: RB_VALID = 1, RB_DATA = shift register MSB; on RB_VALID && RB_READY shift left and decrement; transfer with counter == 0 -> IDLE.
REQ-025 RB_READY low holds RB_DATA and RB_VALID stable.
REQ-026 CFG_START or RB_REQ while BUSY is ignored and sets CFG_ERR; the operation in progress continues unaffected.
REQ-027 CFG_ERR clears only on RST or on an accepted CFG_START in IDLE.
REQ-028 Shadow and readback share one 2^K-bit shift register; counter width is K bits.

Reset
REQ-029 RST: state = IDLE, active table = INIT, shift register = 0, counter = 0, CFG_ERR = 0.
REQ-030 Reset values: CFG_READY = 0, RB_VALID = 0, RB_DATA = 0, BUSY = 0, O = INIT[I].
REQ-031 RST during LOAD or READ aborts the operation; partial shadow data is discarded and never committed.

Structure
REQ-032 Shared package hal_cfg_lut_pkg holds the FSM state enum, K_MIN = 2, K_MAX = 6 and the table-width function 2^K.
REQ-033 Sub-module hal_cfg_shreg: 2^K-bit shift register with parallel load, serial in, MSB serial out and shift enable; instantiated once.
REQ-034 hal_cfg_lut4 holds the FSM, counter, active table and output mux.

Verification (K = 4, INIT = 16'h8000)
REQ-035 After RST, sweep I over 0..15 -> O = 1 only for I = 4'hF; BUSY = 0.
REQ-036 Load 16'h6996 with CFG_VALID pattern 1,0,1,1,... -> O unchanged through COMMIT; next cycle I = 4'b0001 -> O = 1, I = 4'b0011 -> O = 0.
REQ-037 RB_REQ after that load -> RB_DATA sequence 0110100110010110; RB_READY low for 3 cycles mid-stream -> RB_DATA held; BUSY drops after bit 16.
REQ-038 CFG_START during LOAD at bit 5 -> CFG_ERR = 1, load completes with the original data; next accepted CFG_START in IDLE -> CFG_ERR = 0.
REQ-039 RST after 8 bits of LOAD -> state IDLE, O follows 16'h8000, then a fresh RB_REQ reads back 16'h8000.
REQ-040 CFG_START and RB_REQ together in IDLE -> LOAD entered, RB_VALID stays 0, CFG_ERR stays 0.
